// File: rtl/dog_sub_cmp.sv
// Difference-of-Gaussians subtract/compare: exact signed a-b, |a-b| > thr flag, per-frame flag count and diff extremes.
// Two-stage pipeline, global stall while the output is held; frame summary pulses the cycle after the last-sample transfer.
module dog_sub_cmp #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic                   in_signed,
  input  logic                   in_last,
  input  logic [DATA_W-1:0]      thr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DATA_W:0] out_diff,
  output logic                   out_flag,
  output logic                   stats_valid,
  output logic [CNT_W-1:0]       stats_cnt,
  output logic signed [DATA_W:0] stats_max,
  output logic signed [DATA_W:0] stats_min
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic stall;
  logic out_xfer;

  assign stall    = out_valid & ~out_ready;
  // Reset clears the pipeline anyway, so the block is ready throughout it.
  assign in_ready = rst | ~stall;
  assign out_xfer = out_valid & out_ready;

  // One extra bit holds every difference of two DATA_W operands exactly.
  logic signed [DATA_W:0] ext_a;
  logic signed [DATA_W:0] ext_b;
  logic signed [DATA_W:0] diff_c;

  always_comb begin
    ext_a  = in_signed ? {in_a[DATA_W-1], in_a} : {1'b0, in_a};
    ext_b  = in_signed ? {in_b[DATA_W-1], in_b} : {1'b0, in_b};
    diff_c = ext_a - ext_b;
  end

  logic                   s1_vld;
  logic                   s1_last;
  logic signed [DATA_W:0] s1_diff;
  logic [DATA_W-1:0]      s1_thr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_diff <= '0;
      s1_thr  <= '0;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_diff <= diff_c;
        s1_thr  <= thr;
        s1_last <= in_last;
      end
    end
  end

  // The most negative difference is -(2^DATA_W - 1), so the magnitude always fits DATA_W bits.
  logic [DATA_W:0]   s1_neg;
  logic [DATA_W-1:0] s1_mag;
  logic              s1_flag;

  always_comb begin
    s1_neg  = -s1_diff;
    s1_mag  = s1_diff[DATA_W] ? s1_neg[DATA_W-1:0] : s1_diff[DATA_W-1:0];
    s1_flag = s1_mag > s1_thr;
  end

  logic out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_flag  <= 1'b0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_diff <= s1_diff;
        out_flag <= s1_flag;
        out_last <= s1_last;
      end
    end
  end

  // Running accumulators; the stats_* outputs are snapshots taken at the frame's last transfer.
  logic                   acc_first;
  logic [CNT_W-1:0]       acc_cnt;
  logic signed [DATA_W:0] acc_max;
  logic signed [DATA_W:0] acc_min;
  logic [CNT_W-1:0]       cnt_nxt;
  logic signed [DATA_W:0] max_nxt;
  logic signed [DATA_W:0] min_nxt;

  always_comb begin
    cnt_nxt = acc_cnt;
    if (acc_first) begin
      cnt_nxt = out_flag ? CNT_ONE : '0;
    end else if (out_flag && !(&acc_cnt)) begin
      cnt_nxt = acc_cnt + CNT_ONE;
    end
    max_nxt = (acc_first || (out_diff > acc_max)) ? out_diff : acc_max;
    min_nxt = (acc_first || (out_diff < acc_min)) ? out_diff : acc_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_first   <= 1'b1;
      acc_cnt     <= '0;
      acc_max     <= '0;
      acc_min     <= '0;
      stats_valid <= 1'b0;
      stats_cnt   <= '0;
      stats_max   <= '0;
      stats_min   <= '0;
    end else begin
      stats_valid <= out_xfer & out_last;
      if (out_xfer) begin
        acc_cnt   <= cnt_nxt;
        acc_max   <= max_nxt;
        acc_min   <= min_nxt;
        acc_first <= out_last;
        if (out_last) begin
          stats_cnt <= cnt_nxt;
          stats_max <= max_nxt;
          stats_min <= min_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dog_sub_cmp.sv
// Directed bench for dog_sub_cmp: latency, both extension modes, backpressure, frame statistics and mid-frame reset.
module tb_dog_sub_cmp;
  localparam int DW = 9;
  localparam int CW = 19;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_a;
  logic [DW-1:0]       in_b;
  logic                in_signed;
  logic                in_last;
  logic [DW-1:0]       thr;
  logic                out_valid;
  logic                out_ready;
  logic signed [DW:0]  out_diff;
  logic                out_flag;
  logic                stats_valid;
  logic [CW-1:0]       stats_cnt;
  logic signed [DW:0]  stats_max;
  logic signed [DW:0]  stats_min;

  dog_sub_cmp #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last), .thr(thr),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff), .out_flag(out_flag),
    .stats_valid(stats_valid), .stats_cnt(stats_cnt), .stats_max(stats_max), .stats_min(stats_min)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic signed [DW:0] q_diff[$];
  logic               q_flag[$];
  logic [CW-1:0]      q_cnt[$];
  logic signed [DW:0] q_max[$];
  logic signed [DW:0] q_min[$];
  logic               saw_stall;

  // Inputs change 2 time units after a rising edge, so the falling edge sees settled values.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_diff.push_back(out_diff);
        q_flag.push_back(out_flag);
      end
      if (stats_valid) begin
        q_cnt.push_back(stats_cnt);
        q_max.push_back(stats_max);
        q_min.push_back(stats_min);
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_q();
    q_diff.delete(); q_flag.delete();
    q_cnt.delete(); q_max.delete(); q_min.delete();
    saw_stall = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn,
                      input logic [DW-1:0] t, input logic last);
    bit acc;
    acc = 1'b0;
    in_a = a; in_b = b; in_signed = sgn; thr = t; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_accept: a=%0d b=%0d not accepted within 50 cycles", a, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_last = 1'b0; thr = '0;
    idle(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (stats_valid !== 1'b0) begin failures++; $display("FAIL rst_stats_valid: got %b want 0", stats_valid); end
    checks++; if (stats_cnt !== '0) begin failures++; $display("FAIL rst_stats_cnt: got %0d want 0", stats_cnt); end
    checks++; if (stats_max !== '0 || stats_min !== '0) begin failures++; $display("FAIL rst_stats_ext: got %0d/%0d want 0/0", stats_max, stats_min); end
    checks++; if (out_diff !== '0 || out_flag !== 1'b0) begin failures++; $display("FAIL rst_out: got %0d/%b want 0/0", out_diff, out_flag); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_latency();
    clear_q();
    in_a = 9'd5; in_b = 9'd6; in_signed = 1'b0; thr = 9'd0; in_last = 1'b1; in_valid = 1'b1;
    idle(1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_t1_valid: got %b want 0", out_valid); end
    idle(1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_t2_valid: got %b want 1", out_valid); end
    checks++; if (out_diff !== -10'sd1 || out_flag !== 1'b1) begin failures++; $display("FAIL lat_t2_data: got %0d/%b want -1/1", out_diff, out_flag); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_t3_valid: got %b want 0", out_valid); end
    checks++; if (stats_valid !== 1'b1) begin failures++; $display("FAIL lat_stats_pulse: got %b want 1", stats_valid); end
    checks++; if (stats_cnt !== 19'd1 || stats_max !== -10'sd1 || stats_min !== -10'sd1) begin
      failures++; $display("FAIL lat_stats: got cnt=%0d max=%0d min=%0d want 1/-1/-1", stats_cnt, stats_max, stats_min); end
    idle(1);
    checks++; if (stats_valid !== 1'b0 || stats_cnt !== 19'd1) begin
      failures++; $display("FAIL lat_stats_hold: got v=%b cnt=%0d want 0/1", stats_valid, stats_cnt); end
  endtask

  task automatic test_unsigned();
    logic signed [DW:0] ed [3];
    logic               ef [3];
    ed = '{-10'sd1, 10'sd1, 10'sd0};
    ef = '{1'b1, 1'b1, 1'b0};
    clear_q();
    send(9'd5, 9'd6, 1'b0, 9'd0, 1'b0);
    send(9'd6, 9'd5, 1'b0, 9'd0, 1'b0);
    send(9'd6, 9'd6, 1'b0, 9'd0, 1'b1);
    idle(4);
    checks++; if (q_diff.size() != 3) begin failures++; $display("FAIL uns_count: got %0d want 3", q_diff.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_diff.size() || q_diff[i] !== ed[i] || q_flag[i] !== ef[i]) begin
        failures++; $display("FAIL uns_out[%0d]: want %0d/%b", i, ed[i], ef[i]); end
    end
    checks++;
    if (q_cnt.size() != 1 || q_cnt[0] !== 19'd2 || q_max[0] !== 10'sd1 || q_min[0] !== -10'sd1) begin
      failures++; $display("FAIL uns_stats: pulses=%0d want 1 with cnt=2 max=1 min=-1", q_cnt.size()); end
  endtask

  task automatic test_signed();
    logic signed [DW:0] ed [4];
    logic               ef [4];
    ed = '{-10'sd8, -10'sd8, 10'sd511, -10'sd511};
    ef = '{1'b0, 1'b1, 1'b1, 1'b1};
    clear_q();
    send(9'h1FB, 9'd3, 1'b1, 9'd8, 1'b0);
    send(9'h1FB, 9'd3, 1'b1, 9'd7, 1'b0);
    send(9'h1FF, 9'd0, 1'b0, 9'd0, 1'b0);
    send(9'h100, 9'h0FF, 1'b1, 9'd0, 1'b1);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_diff.size() || q_diff[i] !== ed[i] || q_flag[i] !== ef[i]) begin
        failures++; $display("FAIL sgn_out[%0d]: want %0d/%b", i, ed[i], ef[i]); end
    end
    checks++;
    if (q_cnt.size() != 1 || q_cnt[0] !== 19'd3 || q_max[0] !== 10'sd511 || q_min[0] !== -10'sd511) begin
      failures++; $display("FAIL sgn_stats: pulses=%0d want 1 with cnt=3 max=511 min=-511", q_cnt.size()); end
  endtask

  task automatic test_backpressure();
    logic signed [DW:0] ed [6];
    logic               ef [6];
    ed = '{10'sd10, 10'sd8, 10'sd6, 10'sd4, 10'sd2, 10'sd0};
    ef = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_q();
    fork
      begin
        for (int i = 0; i < 6; i++) send(DW'(10 + i), DW'(3 * i), 1'b0, 9'd5, (i == 5));
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(6);
    checks++; if (saw_stall !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drop: got %b want 1", saw_stall); end
    checks++; if (q_diff.size() != 6) begin failures++; $display("FAIL bp_count: got %0d want 6", q_diff.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= q_diff.size() || q_diff[i] !== ed[i] || q_flag[i] !== ef[i]) begin
        failures++; $display("FAIL bp_out[%0d]: want %0d/%b", i, ed[i], ef[i]); end
    end
    checks++;
    if (q_cnt.size() != 1 || q_cnt[0] !== 19'd3 || q_max[0] !== 10'sd10 || q_min[0] !== 10'sd0) begin
      failures++; $display("FAIL bp_stats: pulses=%0d want 1 with cnt=3 max=10 min=0", q_cnt.size()); end
  endtask

  task automatic test_frame_stats();
    clear_q();
    send(9'd3, 9'd0, 1'b0, 9'd4, 1'b0);
    send(9'd0, 9'd7, 1'b0, 9'd4, 1'b0);
    send(9'd10, 9'd0, 1'b0, 9'd4, 1'b0);
    send(9'd0, 9'd2, 1'b0, 9'd4, 1'b1);
    idle(4);
    checks++;
    if (q_cnt.size() != 1 || q_cnt[0] !== 19'd2 || q_max[0] !== 10'sd10 || q_min[0] !== -10'sd7) begin
      failures++; $display("FAIL frm1_stats: pulses=%0d want 1 with cnt=2 max=10 min=-7", q_cnt.size()); end
    idle(3);
    checks++; if (stats_valid !== 1'b0 || stats_cnt !== 19'd2 || stats_max !== 10'sd10) begin
      failures++; $display("FAIL frm1_hold: got v=%b cnt=%0d max=%0d want 0/2/10", stats_valid, stats_cnt, stats_max); end
    send(9'd1, 9'd0, 1'b0, 9'd0, 1'b0);
    send(9'd0, 9'd4, 1'b0, 9'd9, 1'b1);
    idle(4);
    checks++;
    if (q_cnt.size() != 2 || q_cnt[1] !== 19'd1 || q_max[1] !== 10'sd1 || q_min[1] !== -10'sd4) begin
      failures++; $display("FAIL frm2_stats: pulses=%0d want 2, second cnt=1 max=1 min=-4", q_cnt.size()); end
  endtask

  task automatic test_stall_on_pulse();
    clear_q();
    fork
      begin
        send(9'd2, 9'd0, 1'b0, 9'd0, 1'b1);
        send(9'd0, 9'd1, 1'b0, 9'd0, 1'b1);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(1);
        checks++; if (stats_valid !== 1'b0) begin failures++; $display("FAIL pulse_stall_len: got %b want 0", stats_valid); end
        idle(1);
        out_ready = 1'b1;
      end
    join
    idle(5);
    checks++;
    if (q_cnt.size() != 2 || q_max[0] !== 10'sd2 || q_min[0] !== 10'sd2 || q_max[1] !== -10'sd1 || q_min[1] !== -10'sd1) begin
      failures++; $display("FAIL pulse_stall_stats: pulses=%0d want 2 (2/2 then -1/-1)", q_cnt.size()); end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    send(9'd100, 9'd0, 1'b0, 9'd0, 1'b0);
    idle(3);
    send(9'd7, 9'd0, 1'b0, 9'd0, 1'b0);
    send(9'd8, 9'd0, 1'b0, 9'd0, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || stats_valid !== 1'b0 || stats_cnt !== '0) begin
      failures++; $display("FAIL mid_rst_clear: got v=%b sv=%b cnt=%0d want 0/0/0", out_valid, stats_valid, stats_cnt); end
    idle(4);
    checks++; if (q_cnt.size() != 0 || q_diff.size() != 1) begin
      failures++; $display("FAIL mid_rst_discard: got pulses=%0d outs=%0d want 0/1", q_cnt.size(), q_diff.size()); end
    send(9'd3, 9'd8, 1'b0, 9'd0, 1'b1);
    idle(4);
    checks++;
    if (q_cnt.size() != 1 || q_cnt[0] !== 19'd1 || q_max[0] !== -10'sd5 || q_min[0] !== -10'sd5) begin
      failures++; $display("FAIL mid_rst_newframe: pulses=%0d want 1 with cnt=1 max=-5 min=-5", q_cnt.size()); end
  endtask

  initial begin
    saw_stall = 1'b0;
    test_reset();
    test_latency();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_frame_stats();
    test_stall_on_pulse();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
